// File: rtl/if_fetch_ctrl_if.sv
`default_nettype none
//============================================================================
// if_fetch_ctrl_if : instruction-memory request/grant/rvalid bus bundle
// Rev 1.0
//============================================================================
interface if_fetch_ctrl_if;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_gnt;
   logic        im_rvalid;
   logic [31:0] im_rdata;

   modport master (
      output im_req,
      output im_addr,
      input  im_gnt,
      input  im_rvalid,
      input  im_rdata
   );

   modport slave (
      input  im_req,
      input  im_addr,
      output im_gnt,
      output im_rvalid,
      output im_rdata
   );
endinterface
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
//============================================================================
// if_fetch_ctrl : IF-stage fetch controller, one outstanding memory access
// Rev 1.0
//============================================================================
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   next_pc_sel,
   input  logic [31:0]            target_pc,
   if_fetch_ctrl_if.master        imem,
   output logic [31:0]            pc,
   output logic [31:0]            inst,
   output logic                   stall_IF
);

   localparam logic [1:0] S_REQ   = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_DROP  = 2'd2;
   localparam logic [1:0] S_VALID = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [31:0] r_fetch_pc;
   logic [31:0] w_fetch_pc_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic        w_capture;
   logic [31:0] w_target_aligned;

   assign w_target_aligned = target_pc & 32'hFFFF_FFFC;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_REQ;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A redirect always reloads fetch_pc; the state only decides whether an
   // in-flight response still has to be drained (DROP) before re-issuing.
   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_capture      = 1'b0;
      if (next_pc_sel) begin
         w_fetch_pc_nxt = w_target_aligned;
      end
      case (r_state)
         S_REQ: begin
            if (imem.im_gnt) begin
               w_state_nxt = next_pc_sel ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem.im_rvalid) begin
               if (next_pc_sel) begin
                  w_state_nxt = S_REQ;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_VALID;
               end
            end else if (next_pc_sel) begin
               w_state_nxt = S_DROP;
            end
         end
         S_DROP: begin
            if (imem.im_rvalid) begin
               w_state_nxt = S_REQ;
            end
         end
         S_VALID: begin
            if (next_pc_sel) begin
               w_state_nxt = S_REQ;
            end else if (!stall) begin
               w_state_nxt    = S_REQ;
               w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            end
         end
         default: begin
            w_state_nxt = S_REQ;
         end
      endcase
   end

   always_comb begin
      imem.im_req  = 1'b0;
      imem.im_addr = r_fetch_pc;
      stall_IF     = 1'b1;
      if (rst) begin
         imem.im_req = (r_state == S_REQ);
         stall_IF    = (r_state != S_VALID);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_pc       <= 32'h0000_0000;
         r_inst     <= 32'h0000_0000;
      end else begin
         r_fetch_pc <= w_fetch_pc_nxt;
         if (w_capture) begin
            r_pc   <= r_fetch_pc;
            r_inst <= imem.im_rdata;
         end
      end
   end

   assign pc   = r_pc;
   assign inst = r_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
//============================================================================
// tb_if_fetch_ctrl : directed stimulus with address/presentation scoreboards
// Rev 1.0
//============================================================================
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        next_pc_sel;
   logic [31:0] target_pc;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        stall_IF;

   if_fetch_ctrl_if imem ();

   if_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .next_pc_sel (next_pc_sel),
      .target_pc   (target_pc),
      .imem        (imem),
      .pc          (pc),
      .inst        (inst),
      .stall_IF    (stall_IF)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_pres_q[$];
   logic [63:0] last_pres = 64'h0;
   logic        prev_stall_if = 1'b1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: every accepted request and every newly presented instruction
   // is matched against what the stimulus queued.
   always @(negedge clk) begin
      logic [31:0] ea;
      logic [63:0] ep;
      if (imem.im_req && imem.im_gnt) begin
         if (exp_addr_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL grant_unexpected: got addr %h expected none", imem.im_addr);
         end else begin
            ea = exp_addr_q.pop_front();
            chk("grant_addr", imem.im_addr, ea);
         end
      end
      if (!stall_IF) begin
         if (prev_stall_if) begin
            if (exp_pres_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL present_unexpected: got pc %h inst %h expected none", pc, inst);
            end else begin
               ep = exp_pres_q.pop_front();
               chk("present_pc", pc, ep[63:32]);
               chk("present_inst", inst, ep[31:0]);
               last_pres = ep;
            end
         end else begin
            chk("hold_pc", pc, last_pres[63:32]);
            chk("hold_inst", inst, last_pres[31:0]);
         end
      end
      prev_stall_if <= stall_IF;
   end

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   // Entered at the start of a REQ cycle; leaves at the start of the VALID cycle.
   task automatic fetch(input logic [31:0] a, input logic [31:0] d);
      exp_addr_q.push_back(a);
      imem.im_gnt = 1'b1;
      clk1();
      imem.im_gnt    = 1'b0;
      imem.im_rvalid = 1'b1;
      imem.im_rdata  = d;
      exp_pres_q.push_back({a, d});
      clk1();
      imem.im_rvalid = 1'b0;
      imem.im_rdata  = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b0;
      stall          = 1'b0;
      next_pc_sel    = 1'b0;
      target_pc      = 32'h0;
      imem.im_gnt    = 1'b0;
      imem.im_rvalid = 1'b0;
      imem.im_rdata  = 32'h0;
      repeat (3) clk1();

      chk("rst_stall_IF", {31'h0, stall_IF}, 32'd1);
      chk("rst_im_req", {31'h0, imem.im_req}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_inst", inst, 32'h0);

      // First fetch straight out of reset
      rst = 1'b1;
      fetch(32'h0, 32'h0000_0013);
      chk("first_stall_IF", {31'h0, stall_IF}, 32'd0);
      chk("first_pc", pc, 32'h0);
      chk("first_inst", inst, 32'h0000_0013);

      // Back-to-back sequence 0,4,8
      clk1();
      chk("b2b_addr4", imem.im_addr, 32'h4);
      fetch(32'h4, 32'h0040_0093);
      clk1();
      fetch(32'h8, 32'h0080_0113);

      // Stall held in VALID for three cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clk1();
         chk("stall_im_req", {31'h0, imem.im_req}, 32'd0);
         chk("stall_pc", pc, 32'h8);
      end
      stall = 1'b0;
      clk1();
      chk("after_stall_addr", imem.im_addr, 32'hC);
      chk("after_stall_req", {31'h0, imem.im_req}, 32'd1);
      fetch(32'hC, 32'h00C0_0193);

      // Redirect in WAIT without rvalid -> DROP, late data discarded
      clk1();
      exp_addr_q.push_back(32'h10);
      imem.im_gnt = 1'b1;
      clk1();
      imem.im_gnt = 1'b0;
      next_pc_sel = 1'b1;
      target_pc   = 32'h100;
      clk1();
      next_pc_sel = 1'b0;
      chk("drop_stall_IF", {31'h0, stall_IF}, 32'd1);
      chk("drop_im_req", {31'h0, imem.im_req}, 32'd0);
      imem.im_rvalid = 1'b1;
      imem.im_rdata  = 32'hDEAD_BEEF;
      clk1();
      imem.im_rvalid = 1'b0;
      chk("redir_wait_stall_IF", {31'h0, stall_IF}, 32'd1);
      chk("redir_wait_addr", imem.im_addr, 32'h100);
      fetch(32'h100, 32'h1111_0001);

      // Redirect with stall in VALID
      stall       = 1'b1;
      next_pc_sel = 1'b1;
      target_pc   = 32'h40;
      clk1();
      stall       = 1'b0;
      next_pc_sel = 1'b0;
      chk("redir_valid_stall_IF", {31'h0, stall_IF}, 32'd1);
      chk("redir_valid_addr", imem.im_addr, 32'h40);
      fetch(32'h40, 32'h2222_0002);

      // Misaligned redirect in REQ without grant
      clk1();
      chk("req_addr_44", imem.im_addr, 32'h44);
      next_pc_sel = 1'b1;
      target_pc   = 32'h203;
      clk1();
      next_pc_sel = 1'b0;
      chk("redir_req_aligned", imem.im_addr, 32'h200);
      fetch(32'h200, 32'h3333_0003);

      // Redirect in REQ coinciding with grant -> DROP
      clk1();
      exp_addr_q.push_back(32'h204);
      imem.im_gnt = 1'b1;
      next_pc_sel = 1'b1;
      target_pc   = 32'h300;
      clk1();
      imem.im_gnt = 1'b0;
      next_pc_sel = 1'b0;
      chk("redir_gnt_req", {31'h0, imem.im_req}, 32'd0);
      clk1();
      imem.im_rvalid = 1'b1;
      imem.im_rdata  = 32'h0BAD_0001;
      clk1();
      imem.im_rvalid = 1'b0;
      chk("redir_gnt_addr", imem.im_addr, 32'h300);
      fetch(32'h300, 32'h4444_0004);

      // Redirect in WAIT with rvalid in the same cycle
      clk1();
      exp_addr_q.push_back(32'h304);
      imem.im_gnt = 1'b1;
      clk1();
      imem.im_gnt    = 1'b0;
      imem.im_rvalid = 1'b1;
      imem.im_rdata  = 32'h0BAD_0002;
      next_pc_sel    = 1'b1;
      target_pc      = 32'h500;
      clk1();
      imem.im_rvalid = 1'b0;
      next_pc_sel    = 1'b0;
      chk("redir_wait_rv_addr", imem.im_addr, 32'h500);
      chk("redir_wait_rv_stall", {31'h0, stall_IF}, 32'd1);
      fetch(32'h500, 32'h5555_0005);

      // Stray rvalid in VALID and in REQ
      stall          = 1'b1;
      imem.im_rvalid = 1'b1;
      imem.im_rdata  = 32'hFFFF_FFFF;
      clk1();
      chk("stray_valid_inst", inst, 32'h5555_0005);
      stall          = 1'b0;
      imem.im_rvalid = 1'b0;
      clk1();
      imem.im_rvalid = 1'b1;
      clk1();
      imem.im_rvalid = 1'b0;
      chk("stray_req_req", {31'h0, imem.im_req}, 32'd1);
      chk("stray_req_addr", imem.im_addr, 32'h504);

      // Reset while WAIT, rvalid arriving as reset releases
      exp_addr_q.push_back(32'h504);
      imem.im_gnt = 1'b1;
      clk1();
      imem.im_gnt = 1'b0;
      rst         = 1'b0;
      clk1();
      chk("rst_wait_req", {31'h0, imem.im_req}, 32'd0);
      chk("rst_wait_pc", pc, 32'h0);
      rst            = 1'b1;
      imem.im_rvalid = 1'b1;
      imem.im_rdata  = 32'hCAFE_F00D;
      clk1();
      imem.im_rvalid = 1'b0;
      chk("late_rv_addr", imem.im_addr, 32'h0);
      chk("late_rv_stall", {31'h0, stall_IF}, 32'd1);
      chk("late_rv_pc", pc, 32'h0);
      fetch(32'h0, 32'h1234_5013);

      // PC wrap at the top of the address space
      next_pc_sel = 1'b1;
      target_pc   = 32'hFFFF_FFFC;
      clk1();
      next_pc_sel = 1'b0;
      fetch(32'hFFFF_FFFC, 32'h6666_0006);
      clk1();
      chk("wrap_addr", imem.im_addr, 32'h0);

      repeat (2) clk1();
      chk("addr_queue_empty", exp_addr_q.size(), 32'd0);
      chk("pres_queue_empty", exp_pres_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be a synchronous, active-low reset sampled on the rising edge of clk.
REQ-004 Port stall, input, 1, SHALL be the hazard-unit stall: the IF/ID stage does not consume this cycle.
REQ-005 Port next_pc_sel, input, 1, SHALL be the redirect request (taken branch/jump) from EX.
REQ-006 Port target_pc, input, 32, SHALL be the redirect address, valid when next_pc_sel=1.
REQ-007 Port im_req, output, 1, SHALL be the instruction-memory request strobe.
REQ-008 Port im_addr, output, 32, SHALL be the instruction-memory word address (byte address, bits[1:0]=0).
REQ-009 Port im_gnt, input, 1, SHALL be the memory acceptance of the address in the cycle im_req=1.
REQ-010 Port im_rvalid, input, 1, SHALL be the read-data-valid pulse, at least 1 cycle after the im_gnt cycle.
REQ-011 Port im_rdata, input, 32, SHALL be the instruction word, valid when im_rvalid=1.
REQ-012 Port pc, output, 32, SHALL be the PC of the presented instruction.
REQ-013 Port inst, output, 32, SHALL be the presented instruction word.
REQ-014 Port stall_IF, output, 1, SHALL be 1 whenever pc/inst do not hold a valid, undiscarded instruction.

Function
REQ-015 The block SHALL keep at most one memory transaction outstanding.
REQ-016 The block SHALL implement four states: REQ, WAIT, DROP, VALID.
REQ-017 REQ: im_req=1, im_addr=fetch_pc, stall_IF=1; im_gnt=1 -> WAIT; otherwise stay in REQ.
REQ-018 WAIT: im_req=0, stall_IF=1; im_rvalid=1 -> capture inst<=im_rdata, pc<=fetch_pc, go to VALID.
REQ-019 VALID: stall_IF=0, im_req=0; stall=0 and next_pc_sel=0 -> fetch_pc<=fetch_pc+4 (mod 2^32), go to REQ.
REQ-020 VALID with stall=1 and next_pc_sel=0 SHALL hold pc, inst and the state unchanged.
REQ-021 DROP: im_req=0, stall_IF=1; im_rvalid=1 -> discard im_rdata, leave pc/inst unchanged, go to REQ.
REQ-022 next_pc_sel=1 SHALL take priority over stall in every state and SHALL load fetch_pc<=target_pc.
REQ-023 Redirect in REQ with im_gnt=0: stay in REQ; the new address SHALL appear on im_addr in the next cycle.
REQ-024 Redirect in REQ with im_gnt=1 (address already accepted): go to DROP.
REQ-025 Redirect in WAIT with im_rvalid=0: go to DROP.
REQ-026 Redirect in WAIT with im_rvalid=1: discard the data and go to REQ.
REQ-027 Redirect in VALID: go to REQ and SHALL force stall_IF=1 from the next cycle; the presented instruction is dropped.
REQ-028 im_rvalid in REQ or VALID (no outstanding transaction) SHALL be ignored.
REQ-029 Minimum issue-to-present latency SHALL be 2 cycles (REQ with gnt, then WAIT with rvalid), giving stall_IF=0 in the 3rd cycle.
REQ-030 A redirect with target_pc[1:0]!=0 SHALL load the address with bits[1:0] forced to 0.

Reset
REQ-031 While rst=0 at a clock edge: state<=REQ, fetch_pc<=RESET_PC, pc<=0, inst<=0.
REQ-032 Reset SHALL force stall_IF=1 and im_req=0 combinationally while rst=0, and SHALL abandon any outstanding transaction.
REQ-033 A late im_rvalid arriving after reset SHALL be ignored, and REQ SHALL issue RESET_PC.

Verification
REQ-034 Reset release, im_gnt=1 at once, im_rvalid=1 with 32'h0000_0013 one cycle later -> im_addr=0, then pc=0, inst=0x13, stall_IF=0 two cycles after the grant.
REQ-035 Back-to-back fetch with stall=0 -> im_addr sequence 0, 4, 8; each word is presented exactly once.
REQ-036 stall=1 for 3 cycles in VALID -> pc/inst stable, im_req=0, and after the stall is released the next im_addr is pc+4.
REQ-037 next_pc_sel=1 with target_pc=0x100 in WAIT, then im_rvalid with 0xDEADBEEF -> data discarded, stall_IF stays 1, next im_addr=0x100.
REQ-038 next_pc_sel=1 and stall=1 in VALID with target_pc=0x40 -> stall_IF=1 next cycle, im_addr=0x40.
REQ-039 rst=0 asserted in WAIT, im_rvalid arriving during reset release -> ignored, im_addr=RESET_PC, pc=0.
